// File: rtl/modn_cnt_pkg.sv
// ---------------------------------------------------------------------------
// modn_cnt_pkg
// Shared definitions for the modulo-N up/down counter family.
//   CNT_UP / CNT_DN : values of the up_dn direction input
//   clog2()         : ceil(log2(v)), usable in constant expressions; sizes the
//                     prescaler phase register and checks WIDTH against MOD
// ---------------------------------------------------------------------------
package modn_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // clog2(1) = 0, clog2(2) = 1, clog2(5) = 3, clog2(8) = 3
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// ---------------------------------------------------------------------------
// modn_updown_counter_if
// Control/status bundle of one counter stage.
//   en, clr, load, load_val, up_dn : control, driven by the master
//   out, tc, wrap                  : status, driven by the counter (slave)
// There is no handshake on this bundle: every control input is sampled at
// each rising clock edge and every status output is valid all the time.
// Modports:
//   master : the user of the counter (drives control, reads status)
//   slave  : the counter itself
// ---------------------------------------------------------------------------
interface modn_updown_counter_if #(
    parameter int WIDTH = 3
);

    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrap;

    modport master (
        output en, clr, load, load_val, up_dn,
        input  out, tc, wrap
    );

    modport slave (
        input  en, clr, load, load_val, up_dn,
        output out, tc, wrap
    );

endinterface

// File: rtl/modn_prescaler.sv
// ---------------------------------------------------------------------------
// modn_prescaler
// Clock-enable divider: tick is high on every PRESCALE-th enabled cycle.
// Only instantiated by modn_updown_counter when MODN_PRESCALE_EN is defined.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset, phase -> 0
//   en    in  advance the phase on this cycle
//   sclr  in  synchronous phase clear (highest synchronous priority)
//   tick  out combinational, high while phase == PRESCALE-1
// The phase wraps to 0 on an enabled tick cycle and holds while en is low.
// With PRESCALE=1 the phase is constant 0 and tick is permanently high.
// ---------------------------------------------------------------------------
module modn_prescaler
    import modn_cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("modn_prescaler: PRESCALE must be >= 1");
    end

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    always_comb begin
        tick = (p_q == LAST);
        p_d  = p_q;
        if (sclr) begin
            p_d = '0;
        end else if (en) begin
            p_d = tick ? '0 : p_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
// Parametrised modulo-MOD up/down counter with count enable, synchronous
// clear, saturating parallel load, combinational terminal count for
// cascading (tc of one stage -> en of the next) and a registered wrap pulse.
// Parameters: the modulus sets the count range 0..modulus-1 (at least 2);
// WIDTH sizes out/load_val and must cover the modulus; PRESCALE divides the
// step rate and is only used when the prescaler is compiled in.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset (out=0, wrap=0, tc=0)
//   cnt    slave modport of modn_updown_counter_if:
//          en, clr, load, load_val, up_dn in; out, tc, wrap out
// Configuration macro:
//   MODN_PRESCALE_EN  defined   -> modn_prescaler divides the step rate
//                     undefined -> every enabled cycle is a step
// Priority at each edge: clr > load > step > hold.
// ---------------------------------------------------------------------------
module modn_updown_counter
    import modn_cnt_pkg::*;
#(
    parameter int MOD      = 5,
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    modn_updown_counter_if.slave   cnt
);

    if (MOD < 2) begin : g_bad_mod
        $error("modn_updown_counter: MOD must be >= 2");
    end
    if (clog2(MOD) > WIDTH) begin : g_bad_width
        $error("modn_updown_counter: WIDTH too small for MOD");
    end

    // One extra bit on the arithmetic so out+1 at 2**WIDTH-1 cannot alias
    // back into range and the borrow of out-1 is visible.
    localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MOD - 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             tick;
    logic             step;
    logic             at_wrap;
    logic [WIDTH:0]   out_x;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic [WIDTH:0]   load_x;

`ifdef MODN_PRESCALE_EN
    modn_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (cnt.en),
        .sclr  (cnt.clr | cnt.load),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        out_x   = {1'b0, out_q};
        load_x  = {1'b0, cnt.load_val};
        inc_x   = out_x + 1'b1;
        dec_x   = out_x - 1'b1;
        step    = cnt.en & tick;
        at_wrap = (cnt.up_dn == CNT_UP) ? (out_x == MAX_X) : (out_x == '0);

        out_d  = out_q;
        wrap_d = 1'b0;
        if (cnt.clr) begin
            out_d = '0;
        end else if (cnt.load) begin
            // Out-of-range load values saturate to MOD-1.
            out_d = (load_x < MOD_X) ? cnt.load_val : MAX_X[WIDTH-1:0];
        end else if (step) begin
            if (cnt.up_dn == CNT_UP) begin
                // >= rather than == keeps out inside 0..MOD-1 by construction.
                if (inc_x >= MOD_X) begin
                    out_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    out_d = inc_x[WIDTH-1:0];
                end
            end else begin
                // Borrow out of the extra bit means out was 0.
                if (dec_x[WIDTH]) begin
                    out_d  = MAX_X[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    out_d = dec_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt.out  = out_q;
    assign cnt.wrap = wrap_q;
    // Unregistered so a cascaded stage steps on the same edge; forced low
    // during reset because out=0 would otherwise decode as a down wrap point.
    assign cnt.tc   = ~reset & step & ~cnt.clr & ~cnt.load & at_wrap;

endmodule

// File: tb/tb_modn_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_updown_counter
// Directed bench for modn_updown_counter (MOD=5, WIDTH=3): reset, counting
// both ways, direction reversal at the boundaries, clear/load priority and
// saturation, two cascaded stages, and (with MODN_PRESCALE_EN) a PRESCALE=3
// instance.
// ---------------------------------------------------------------------------
module tb_modn_updown_counter;

    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    logic [2:0] exp_q[$];

    modn_updown_counter_if #(.WIDTH(3)) if0 ();
    modn_updown_counter_if #(.WIDTH(3)) if1 ();

    modn_updown_counter #(.MOD(5), .WIDTH(3), .PRESCALE(1)) u_stage0 (
        .clk   (clk),
        .reset (reset),
        .cnt   (if0.slave)
    );

    modn_updown_counter #(.MOD(5), .WIDTH(3), .PRESCALE(1)) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .cnt   (if1.slave)
    );

    // Cascade: stage1 steps whenever stage0 is at its carry point.
    assign if1.en = if0.tc;

`ifdef MODN_PRESCALE_EN
    modn_updown_counter_if #(.WIDTH(3)) if2 ();

    modn_updown_counter #(.MOD(5), .WIDTH(3), .PRESCALE(3)) u_pre (
        .clk   (clk),
        .reset (reset),
        .cnt   (if2.slave)
    );
`endif

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick_clk(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic en, input logic clr, input logic load,
                          input logic [2:0] val, input logic up);
        if0.en       = en;
        if0.clr      = clr;
        if0.load     = load;
        if0.load_val = val;
        if0.up_dn    = up;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        if1.clr      = 1'b0;
        if1.load     = 1'b0;
        if1.load_val = 3'd0;
        if1.up_dn    = 1'b1;
`ifdef MODN_PRESCALE_EN
        if2.en       = 1'b0;
        if2.clr      = 1'b0;
        if2.load     = 1'b0;
        if2.load_val = 3'd0;
        if2.up_dn    = 1'b1;
`endif

        // Reset state; en=1 and down at out=0 would be a wrap point if not in reset.
        tick_clk(2);
        check("rst_out", if0.out, 0);
        check("rst_wrap", if0.wrap, 0);
        check("rst_tc", if0.tc, 0);
        reset = 1'b0;

        // Count up to 3, then reset with no clock edge.
        drive0(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        tick_clk(3);
        check("pre_rst_out", if0.out, 3);
        reset = 1'b1;
        #1;
        check("async_rst_out", if0.out, 0);
        check("async_rst_wrap", if0.wrap, 0);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick_clk();
            check("post_rst_up", if0.out, i);
        end

        // clr beats an active step at the wrap point.
        if0.clr = 1'b1;
        #1;
        check("clr_tc", if0.tc, 0);
        tick_clk();
        check("clr_out", if0.out, 0);
        check("clr_wrap", if0.wrap, 0);
        if0.clr = 1'b0;

        // 12 cycles counting up from 0.
        for (int i = 0; i < 12; i++) exp_q.push_back(3'(i % 5));
        for (int i = 0; i < 12; i++) begin
            logic [2:0] e;
            if (i > 0) tick_clk();
            e = exp_q.pop_front();
            check("up_out", if0.out, e);
            check("up_tc", if0.tc, (e == 3'd4) ? 1 : 0);
            check("up_wrap", if0.wrap, (i > 0 && e == 3'd0) ? 1 : 0);
        end

        // Down from 1: 0, 4, 3.
        if0.up_dn = 1'b0;
        #1;
        check("dn1_tc", if0.tc, 0);
        tick_clk();
        check("dn_out0", if0.out, 0);
        check("dn_tc0", if0.tc, 1);
        check("dn_wrap0", if0.wrap, 0);
        tick_clk();
        check("dn_out4", if0.out, 4);
        check("dn_wrap4", if0.wrap, 1);
        check("dn_tc4", if0.tc, 0);
        tick_clk();
        check("dn_out3", if0.out, 3);
        check("dn_wrap3", if0.wrap, 0);

        // Up to 4, then wrap to 0.
        if0.up_dn = 1'b1;
        tick_clk();
        check("rev_out4", if0.out, 4);
        check("rev_tc4", if0.tc, 1);
        tick_clk();
        check("rev_out0", if0.out, 0);
        check("rev_wrap0", if0.wrap, 1);

        // Reverse to down at 0: wraps to MOD-1.
        if0.up_dn = 1'b0;
        #1;
        check("rev0_tc", if0.tc, 1);
        tick_clk();
        check("rev0_out", if0.out, 4);
        check("rev0_wrap", if0.wrap, 1);

        // Hold with en=0.
        if0.en = 1'b0;
        #1;
        check("hold_tc", if0.tc, 0);
        tick_clk();
        check("hold_out", if0.out, 4);
        check("hold_wrap", if0.wrap, 0);

        // Loads and saturation.
        drive0(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
        tick_clk();
        check("ld3", if0.out, 3);
        if0.load_val = 3'd7;
        tick_clk();
        check("ld7_sat", if0.out, 4);
        if0.load_val = 3'd0;
        tick_clk();
        check("ld0", if0.out, 0);
        if0.load_val = 3'd5;
        tick_clk();
        check("ld5_sat", if0.out, 4);
        if0.load_val = 3'd4;
        tick_clk();
        check("ld4", if0.out, 4);

        // Load with en=1 at the up wrap point: load wins, no tc, no wrap.
        drive0(1'b1, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        check("ld_en_tc", if0.tc, 0);
        tick_clk();
        check("ld_en_out", if0.out, 2);
        check("ld_en_wrap", if0.wrap, 0);

        // clr together with load.
        drive0(1'b0, 1'b1, 1'b1, 3'd2, 1'b1);
        tick_clk();
        check("clr_ld_out", if0.out, 0);

        // Cascade: clear both stages, then 30 enabled cycles.
        if1.clr = 1'b1;
        tick_clk();
        if1.clr = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        check("casc_s0_start", if0.out, 0);
        check("casc_s1_start", if1.out, 0);
        for (int k = 1; k <= 30; k++) begin
            tick_clk();
            if (k == 4) begin
                check("casc4_s1", if1.out, 0);
            end
            if (k == 5) begin
                check("casc5_s0", if0.out, 0);
                check("casc5_s1", if1.out, 1);
            end
            if (k == 24) begin
                check("casc24_s0", if0.out, 4);
                check("casc24_s1", if1.out, 4);
                check("casc24_tc1", if1.tc, 1);
            end
            if (k == 25) begin
                check("casc25_s0", if0.out, 0);
                check("casc25_s1", if1.out, 0);
                check("casc25_wrap1", if1.wrap, 1);
            end
            if (k == 30) begin
                check("casc30_s1", if1.out, 1);
            end
        end
        if0.en = 1'b0;

`ifdef MODN_PRESCALE_EN
        // PRESCALE=3: one step per three enabled cycles.
        if2.clr = 1'b1;
        tick_clk();
        if2.clr = 1'b0;
        if2.en  = 1'b1;
        tick_clk();
        check("pre_e1", if2.out, 0);
        check("pre_tc_p1", if2.tc, 0);
        tick_clk();
        check("pre_e2", if2.out, 0);
        tick_clk();
        check("pre_e3", if2.out, 1);
        tick_clk();
        check("pre_e4", if2.out, 1);
        // Two idle cycles delay the next step by two.
        if2.en = 1'b0;
        tick_clk(2);
        check("pre_idle", if2.out, 1);
        if2.en = 1'b1;
        tick_clk();
        check("pre_e5", if2.out, 1);
        tick_clk();
        check("pre_e6", if2.out, 2);
        // Load clears the phase.
        tick_clk();
        if2.load     = 1'b1;
        if2.load_val = 3'd0;
        tick_clk();
        if2.load = 1'b0;
        check("pre_ld", if2.out, 0);
        tick_clk(2);
        check("pre_ld2", if2.out, 0);
        tick_clk();
        check("pre_ld3", if2.out, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
